// File: rtl/nand_seq_pkg.sv
// Shared types for the NAND logic sequencer.
// Contents:
//   op_e     - function select (NAND..PASSA = 0..7)
//   state_e  - sequencer states (IDLE, EXEC, DONE)
//   src_e    - NAND operand source register select
//   dst_e    - NAND result destination register select
//   op_steps - number of NAND evaluations (k) each function needs
package nand_seq_pkg;

  localparam int unsigned STEP_W = 3;

  typedef enum logic [2:0] {
    OP_NAND  = 3'd0,
    OP_AND   = 3'd1,
    OP_OR    = 3'd2,
    OP_NOR   = 3'd3,
    OP_XOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOTA  = 3'd6,
    OP_PASSA = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SRC_RA = 3'd0,
    SRC_RB = 3'd1,
    SRC_RT = 3'd2,
    SRC_RU = 3'd3,
    SRC_RV = 3'd4
  } src_e;

  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RU = 2'd1,
    DST_RV = 2'd2,
    DST_C  = 2'd3
  } dst_e;

  function automatic logic [STEP_W-1:0] op_steps(input op_e op);
    case (op)
      OP_NAND:  op_steps = 3'd1;
      OP_AND:   op_steps = 3'd2;
      OP_OR:    op_steps = 3'd3;
      OP_NOR:   op_steps = 3'd4;
      OP_XOR:   op_steps = 3'd4;
      OP_XNOR:  op_steps = 3'd5;
      OP_NOTA:  op_steps = 3'd1;
      default:  op_steps = 3'd2;   // OP_PASSA
    endcase
  endfunction

endpackage

// File: rtl/nand_seq_ucode.sv
// Combinational micro-program ROM for the NAND sequencer.
// Ports:
//   op    in  function being executed
//   step  in  current micro-step index (0-based)
//   src_p out first NAND operand source
//   src_q out second NAND operand source
//   dst   out destination of the NAND result
//   last  out high on the final micro-step of the function
module nand_seq_ucode
  import nand_seq_pkg::*;
(
  input  op_e               op,
  input  logic [STEP_W-1:0] step,
  output src_e              src_p,
  output src_e              src_q,
  output dst_e              dst,
  output logic              last
);

  always_comb begin
    src_p = SRC_RA;
    src_q = SRC_RA;
    dst   = DST_C;
    last  = (step == (op_steps(op) - 3'd1));
    case (op)
      OP_NAND: begin
        src_q = SRC_RB;
      end
      OP_AND, OP_PASSA: begin
        case (step)
          3'd0: begin
            src_q = (op == OP_AND) ? SRC_RB : SRC_RA;
            dst   = DST_RT;
          end
          default: begin
            src_p = SRC_RT; src_q = SRC_RT;
          end
        endcase
      end
      // NOR runs the OR sequence into V, then inverts V.
      OP_OR, OP_NOR: begin
        case (step)
          3'd0: dst = DST_RT;
          3'd1: begin
            src_p = SRC_RB; src_q = SRC_RB; dst = DST_RU;
          end
          3'd2: begin
            src_p = SRC_RT; src_q = SRC_RU;
            dst   = (op == OP_NOR) ? DST_RV : DST_C;
          end
          default: begin
            src_p = SRC_RV; src_q = SRC_RV;
          end
        endcase
      end
      // XNOR runs the XOR sequence into T, then inverts T.
      OP_XOR, OP_XNOR: begin
        case (step)
          3'd0: begin
            src_q = SRC_RB; dst = DST_RT;
          end
          3'd1: begin
            src_q = SRC_RT; dst = DST_RU;
          end
          3'd2: begin
            src_p = SRC_RB; src_q = SRC_RT; dst = DST_RV;
          end
          3'd3: begin
            src_p = SRC_RU; src_q = SRC_RV;
            dst   = (op == OP_XNOR) ? DST_RT : DST_C;
          end
          default: begin
            src_p = SRC_RT; src_q = SRC_RT;
          end
        endcase
      end
      default: begin
        // OP_NOTA: single ~(A&A)
      end
    endcase
  end

endmodule

// File: rtl/nand_logic_sequencer.sv
// Multi-cycle bitwise logic unit built on a single shared N-bit NAND stage.
// One NAND evaluation per EXEC cycle; function selected by op (see op_e).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake (in_ready high only in IDLE)
//   op, a, b             function select and operands, sampled on accept
//   out_valid/out_ready  result handshake; c held stable while in DONE
//   c                    result
//   nand_evals           (only with NAND_SEQ_STATS_EN) saturating count of
//                        EXEC cycles
module nand_logic_sequencer
  import nand_seq_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c
`ifdef NAND_SEQ_STATS_EN
  ,
  output logic [31:0]  nand_evals
`endif
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [N-1:0]      ra_q, ra_d, rb_q, rb_d;
  logic [N-1:0]      rt_q, rt_d, ru_q, ru_d, rv_q, rv_d;
  logic [N-1:0]      c_q, c_d;

  src_e       src_p, src_q;
  dst_e       dst;
  logic       last;
  logic [N-1:0] nand_p, nand_q, nand_x;

  nand_seq_ucode u_ucode (
    .op    (op_q),
    .step  (step_q),
    .src_p (src_p),
    .src_q (src_q),
    .dst   (dst),
    .last  (last)
  );

  function automatic logic [N-1:0] pick(input src_e s, input logic [N-1:0] ra,
                                        input logic [N-1:0] rb, input logic [N-1:0] rt,
                                        input logic [N-1:0] ru, input logic [N-1:0] rv);
    case (s)
      SRC_RA:  pick = ra;
      SRC_RB:  pick = rb;
      SRC_RT:  pick = rt;
      SRC_RU:  pick = ru;
      default: pick = rv;
    endcase
  endfunction

  always_comb begin
    nand_p = pick(src_p, ra_q, rb_q, rt_q, ru_q, rv_q);
    nand_q = pick(src_q, ra_q, rb_q, rt_q, ru_q, rv_q);
    nand_x = ~(nand_p & nand_q);
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign c         = c_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    step_d  = step_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rt_d    = rt_q;
    ru_d    = ru_q;
    rv_d    = rv_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          ra_d    = a;
          rb_d    = b;
          op_d    = op_e'(op);
          step_d  = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (dst)
          DST_RT:  rt_d = nand_x;
          DST_RU:  ru_d = nand_x;
          DST_RV:  rv_d = nand_x;
          default: c_d  = nand_x;
        endcase
        if (last) state_d = ST_DONE;
        else      step_d  = step_q + 3'd1;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NAND;
      step_q  <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rt_q    <= '0;
      ru_q    <= '0;
      rv_q    <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      step_q  <= step_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rt_q    <= rt_d;
      ru_q    <= ru_d;
      rv_q    <= rv_d;
      c_q     <= c_d;
    end
  end

`ifdef NAND_SEQ_STATS_EN
  logic [31:0] evals_q, evals_d;

  always_comb begin
    evals_d = evals_q;
    if ((state_q == ST_EXEC) && (evals_q != '1)) evals_d = evals_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) evals_q <= '0;
    else     evals_q <= evals_d;
  end

  assign nand_evals = evals_q;
`endif

endmodule

// File: tb/tb_nand_logic_sequencer.sv
module tb_nand_logic_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] c;
`ifdef NAND_SEQ_STATS_EN
  logic [31:0] nand_evals;
`endif

  int checks = 0;
  int errors = 0;

  nand_logic_sequencer #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
`ifdef NAND_SEQ_STATS_EN
    ,
    .nand_evals(nand_evals)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus driver: called at #1 after a rising edge. Waits (bounded) for
  // in_ready, offers one operation, scrambles a/b/op right after the accept
  // edge, then counts edges until out_valid. lat = -1 on any timeout.
  task automatic do_op(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                       output int lat, output logic [7:0] res);
    int w;
    lat = -1;
    res = '0;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (in_ready !== 1'b1) return;
    op = o; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~av; b = ~bv; op = ~o;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        lat = i;
        res = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready_low got %b want 0", in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready_first got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (c !== 8'h00) begin
      errors++; $display("FAIL reset_c got %h want 00", c);
    end
`ifdef NAND_SEQ_STATS_EN
    checks++;
    if (nand_evals !== 32'd0) begin
      errors++; $display("FAIL reset_evals got %0d want 0", nand_evals);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_simple_ops;
    logic [2:0] ops  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [7:0] exps [6] = '{8'h3F, 8'hC0, 8'hFC, 8'h03, 8'h3C, 8'hC3};
    int         lats [6] = '{1, 2, 3, 4, 4, 5};
    int lat;
    logic [7:0] res;
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], 8'hF0, 8'hCC, lat, res);
      checks++;
      if (res !== exps[i]) begin
        errors++; $display("FAIL op%0d_result got %h want %h", ops[i], res, exps[i]);
      end
      checks++;
      if (lat !== lats[i]) begin
        errors++; $display("FAIL op%0d_latency got %0d want %0d", ops[i], lat, lats[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL op%0d_handshake_done got in_ready=%b out_valid=%b want 1/0",
                           ops[i], in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [7:0] res;
    out_ready = 1'b0;
    do_op(3'd1, 8'hF0, 8'hCC, lat, res);
    checks++;
    if (res !== 8'hC0 || lat !== 2) begin
      errors++; $display("FAIL bp_and got c=%h lat=%0d want c0 lat 2", res, lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (c !== 8'hC0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc%0d got c=%h ov=%b ir=%b want c0/1/0",
                           i, c, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got ir=%b ov=%b want 1/0", in_ready, out_valid);
    end
    do_op(3'd7, 8'hA5, 8'hCC, lat, res);
    checks++;
    if (res !== 8'hA5 || lat !== 2) begin
      errors++; $display("FAIL passa got c=%h lat=%0d want a5 lat 2", res, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int first = -1;
    int second = -1;
    op = 3'd2; a = 8'hF0; b = 8'hCC; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        checks++;
        if (c !== 8'hFC) begin
          errors++; $display("FAIL b2b_or_result got %h want fc", c);
        end
        if (first < 0) first = i;
        else begin
          second = i;
          break;
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (first < 0 || second - first !== 5) begin
      errors++; $display("FAIL b2b_period got %0d want 5", second - first);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op;
    int lat;
    int seen = 0;
    logic [7:0] res;
    op = 3'd4; a = 8'hF0; b = 8'hCC; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || c !== 8'h00 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_state got ov=%b c=%h ir=%b want 0/00/1",
                         out_valid, c, in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midrst_stale got %0d valid cycles want 0", seen);
    end
    do_op(3'd6, 8'h0F, 8'hCC, lat, res);
    checks++;
    if (res !== 8'hF0 || lat !== 1) begin
      errors++; $display("FAIL nota got c=%h lat=%0d want f0 lat 1", res, lat);
    end
    @(posedge clk); #1;
  endtask

`ifdef NAND_SEQ_STATS_EN
  task automatic test_stats;
    int lat;
    logic [7:0] res;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(3'd0, 8'hF0, 8'hCC, lat, res);
    @(posedge clk); #1;
    do_op(3'd4, 8'hF0, 8'hCC, lat, res);
    @(posedge clk); #1;
    do_op(3'd5, 8'hF0, 8'hCC, lat, res);
    @(posedge clk); #1;
    checks++;
    if (nand_evals !== 32'd10) begin
      errors++; $display("FAIL stats_count got %0d want 10", nand_evals);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (nand_evals !== 32'd0) begin
      errors++; $display("FAIL stats_clear got %0d want 0", nand_evals);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    test_reset();
    test_simple_ops();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
`ifdef NAND_SEQ_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
